usb_loopback_fifo: RTL and testbench



---
 rtl/usb_loopback_fifo.sv | 197 +++++++++++++++++++
 tb/tb_usb_loopback_fifo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_loopback_fifo.sv
// usb_loopback_fifo
//   Elastic loopback between the usb_cdc OUT stream (host -> device) and the
//   IN stream (device -> host), with four runtime modes selected by mode_i:
//     0 echo, 1 uppercase echo, 2 incrementing pattern generator, 3 sink.
//   A mode change is applied through a one-cycle FLUSH that empties the FIFO
//   and restarts the generator.
//
// Ports
//   clk_i       48 MHz USB clock
//   rstn_i      asynchronous active-low reset
//   mode_i      requested mode
//   rx_data_i   byte from host (usb_cdc out_data_o)
//   rx_valid_i  rx_data_i valid
//   rx_ready_o  block accepts rx_data_i
//   tx_data_o   byte to host (usb_cdc in_data_i)
//   tx_valid_o  tx_data_o valid
//   tx_ready_i  host side accepts tx_data_o
//   level_o     FIFO occupancy, 0..DEPTH
//   activity_o  high for ACT_HOLD cycles after the last rx/tx handshake
//
// Optional build macro USB_LOOPBACK_STATS_EN adds
//   rx_count_o  saturating 16-bit count of rx handshakes
//   tx_count_o  saturating 16-bit count of tx handshakes
module usb_loopback_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ACT_HOLD   = 65536
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [1:0]                mode_i,
    input  logic [DATA_WIDTH-1:0]     rx_data_i,
    input  logic                      rx_valid_i,
    output logic                      rx_ready_o,
    output logic [DATA_WIDTH-1:0]     tx_data_o,
    output logic                      tx_valid_o,
    input  logic                      tx_ready_i,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      activity_o
`ifdef USB_LOOPBACK_STATS_EN
    ,
    output logic [15:0]               rx_count_o,
    output logic [15:0]               tx_count_o
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int ACW = $clog2(ACT_HOLD + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [1:0] MODE_ECHO  = 2'd0;
    localparam logic [1:0] MODE_UPPER = 2'd1;
    localparam logic [1:0] MODE_GEN   = 2'd2;
    localparam logic [1:0] MODE_SINK  = 2'd3;

    logic [0:0]            state_q;
    logic [1:0]            mode_q;
    logic                  rst_done_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [LW-1:0]         level_q;
    logic [DATA_WIDTH-1:0] gen_q;
    logic [ACW-1:0]        act_q;

    logic                  fifo_mode;
    logic                  active;
    logic                  rx_ready;
    logic                  tx_valid;
    logic                  rx_hs;
    logic                  tx_hs;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] wr_data;

    assign fifo_mode = (mode_q == MODE_ECHO) || (mode_q == MODE_UPPER);
    assign active    = rst_done_q && (state_q == ST_RUN);

    always_comb begin
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        if (active) begin
            case (mode_q)
                MODE_ECHO, MODE_UPPER: begin
                    rx_ready = (level_q != LW'(DEPTH));
                    tx_valid = (level_q != '0);
                end
                MODE_GEN:  tx_valid = 1'b1;
                MODE_SINK: rx_ready = 1'b1;
                default: ;
            endcase
        end
    end

    // Data is zeroed whenever tx_valid_o is low so the port reads 0 in reset
    // even though the storage array itself is not reset.
    always_comb begin
        tx_data_o = '0;
        if (tx_valid)
            tx_data_o = fifo_mode ? mem[rd_ptr_q] : gen_q;
    end

    assign rx_ready_o = rx_ready;
    assign tx_valid_o = tx_valid;
    assign rx_hs      = rx_valid_i && rx_ready;
    assign tx_hs      = tx_valid && tx_ready_i;
    assign push       = rx_hs && fifo_mode;
    assign pop        = tx_hs && fifo_mode;
    assign level_o    = level_q;
    assign activity_o = (act_q != '0);

    always_comb begin
        wr_data = rx_data_i;
        if (mode_q == MODE_UPPER && rx_data_i[7:0] >= 8'h61 && rx_data_i[7:0] <= 8'h7A)
            wr_data[7:0] = rx_data_i[7:0] - 8'h20;
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_RUN;
            mode_q     <= MODE_ECHO;
            rst_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            gen_q      <= '0;
        end else begin
            rst_done_q <= 1'b1;
            case (state_q)
                ST_RUN: begin
                    if (mode_i != mode_q)
                        state_q <= ST_FLUSH;
                    if (push)
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (pop)
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                    if (push && !pop)
                        level_q <= level_q + LW'(1);
                    else if (pop && !push)
                        level_q <= level_q - LW'(1);
                    if (tx_hs && mode_q == MODE_GEN)
                        gen_q <= gen_q + DATA_WIDTH'(1);
                end
                ST_FLUSH: begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    level_q  <= '0;
                    gen_q    <= '0;
                    mode_q   <= mode_i;
                    state_q  <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            act_q <= '0;
        else if (rx_hs || tx_hs)
            act_q <= ACW'(ACT_HOLD);
        else if (act_q != '0)
            act_q <= act_q - ACW'(1);
    end

`ifdef USB_LOOPBACK_STATS_EN
    logic [15:0] rx_cnt_q;
    logic [15:0] tx_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else if (state_q == ST_FLUSH) begin
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (rx_hs && rx_cnt_q != '1)
                rx_cnt_q <= rx_cnt_q + 16'd1;
            if (tx_hs && tx_cnt_q != '1)
                tx_cnt_q <= tx_cnt_q + 16'd1;
        end
    end

    assign rx_count_o = rx_cnt_q;
    assign tx_count_o = tx_cnt_q;
`endif

endmodule

// File: tb/tb_usb_loopback_fifo.sv
// tb_usb_loopback_fifo
//   Self-checking bench for usb_loopback_fifo (DATA_WIDTH=8, DEPTH=16,
//   ACT_HOLD=8). A queue-based reference model tracks expected outputs every
//   cycle; directed tables and sequences cover echo, uppercase, full/drain,
//   generator wrap, flush, asynchronous reset and activity stretching,
//   followed by randomized traffic with occasional mode changes.
module tb_usb_loopback_fifo;

    localparam int DW       = 8;
    localparam int DEPTH    = 16;
    localparam int ACT_HOLD = 8;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    mode;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [LW-1:0] level;
    logic          activity;
`ifdef USB_LOOPBACK_STATS_EN
    logic [15:0]   rx_count;
    logic [15:0]   tx_count;
`endif

    always #5 clk = ~clk;

    usb_loopback_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ACT_HOLD   (ACT_HOLD)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .mode_i     (mode),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .level_o    (level),
        .activity_o (activity)
`ifdef USB_LOOPBACK_STATS_EN
        ,
        .rx_count_o (rx_count),
        .tx_count_o (tx_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] mq[$];
    int         m_mode;
    bit         m_flush;
    bit         m_done;
    int         m_gen;
    int         m_act;
    int         m_rxc;
    int         m_txc;

    typedef struct {
        logic [1:0] mode;
        logic       rxv;
        logic [7:0] d;
        logic       txr;
        logic       erx;
        logic       etx;
        logic [7:0] ed;
        int         lvl;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] upc(input logic [7:0] d);
        return (d >= 8'h61 && d <= 8'h7A) ? d - 8'h20 : d;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode  = 0;
        m_flush = 0;
        m_done  = 0;
        m_gen   = 0;
        m_act   = 0;
        m_rxc   = 0;
        m_txc   = 0;
    endtask

    // Check current outputs against the model, clock once, advance the model.
    task automatic cycle();
        bit         run;
        bit         erx;
        bit         etx;
        bit         rxh;
        bit         txh;
        logic [7:0] ed;
        run = m_done && !m_flush;
        erx = run && ((m_mode < 2) ? (mq.size() < DEPTH) : (m_mode == 3));
        etx = run && ((m_mode < 2) ? (mq.size() > 0) : (m_mode == 2));
        ed  = 8'h00;
        if (etx) ed = (m_mode < 2) ? mq[0] : m_gen[7:0];
        chk("rx_ready", rx_ready, erx);
        chk("tx_valid", tx_valid, etx);
        chk("tx_data", tx_data, ed);
        chk("level", level, mq.size());
        chk("activity", activity, m_act != 0);
`ifdef USB_LOOPBACK_STATS_EN
        chk("rx_count", rx_count, m_rxc);
        chk("tx_count", tx_count, m_txc);
`endif
        @(posedge clk);
        rxh = rx_valid && erx;
        txh = tx_ready && etx;
        if (m_mode < 2) begin
            if (txh) void'(mq.pop_front());
            if (rxh) mq.push_back(m_mode == 1 ? upc(rx_data) : rx_data);
        end
        if (txh && m_mode == 2) m_gen = (m_gen + 1) % 256;
        if (rxh && m_rxc < 65535) m_rxc++;
        if (txh && m_txc < 65535) m_txc++;
        if (rxh || txh) m_act = ACT_HOLD;
        else if (m_act > 0) m_act--;
        if (m_flush) begin
            mq.delete();
            m_gen   = 0;
            m_rxc   = 0;
            m_txc   = 0;
            m_mode  = mode;
            m_flush = 0;
        end else if (mode != m_mode) begin
            m_flush = 1;
        end
        m_done = 1;
        #1;
    endtask

    task automatic drive(input logic [1:0] md, input logic rv, input logic [7:0] d, input logic tr);
        mode     = md;
        rx_valid = rv;
        rx_data  = d;
        tx_ready = tr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int acc;
        int hi;

        //            mode  rxv d      txr  erx   etx   ed     lvl
        tv[0]  = '{2'd0, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tv[1]  = '{2'd0, 1'b1, 8'h62, 1'b1, 1'b1, 1'b1, 8'h41, 1};
        tv[2]  = '{2'd0, 1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 8'h62, 1};
        tv[3]  = '{2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0A, 1};
        tv[4]  = '{2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tv[5]  = '{2'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tv[6]  = '{2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0};
        tv[7]  = '{2'd1, 1'b1, 8'h61, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tv[8]  = '{2'd1, 1'b1, 8'h7A, 1'b1, 1'b1, 1'b1, 8'h41, 1};
        tv[9]  = '{2'd1, 1'b1, 8'h7B, 1'b1, 1'b1, 1'b1, 8'h5A, 1};
        tv[10] = '{2'd1, 1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 8'h7B, 1};
        tv[11] = '{2'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40, 1};
        tv[12] = '{2'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

        // Reset state
        rstn = 1'b0;
        drive(2'd0, 1'b0, 8'h00, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_level", level, 0);
        chk("rst_activity", activity, 0);
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        cycle();

        // Echo and uppercase echo vectors
        for (int i = 0; i < 13; i++) begin
            drive(tv[i].mode, tv[i].rxv, tv[i].d, tv[i].txr);
            chk("tbl_rx_ready", rx_ready, tv[i].erx);
            chk("tbl_tx_valid", tx_valid, tv[i].etx);
            chk("tbl_tx_data", tx_data, tv[i].ed);
            chk("tbl_level", level, tv[i].lvl);
            cycle();
        end

        // Fill to full with the host stalled, then drain
        drive(2'd0, 1'b0, 8'h00, 1'b0);
        cycle();
        cycle();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            drive(2'd0, 1'b1, 8'(i), 1'b0);
            if (rx_ready) acc++;
            cycle();
        end
        chk("fill_accepted", acc, 16);
        chk("fill_level", level, 16);
        chk("fill_rx_ready", rx_ready, 0);
        drive(2'd0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", tx_data, i);
            if (i == 0) chk("drain_full_rx_ready", rx_ready, 0);
            if (i == 1) chk("drain_reopen_rx_ready", rx_ready, 1);
            cycle();
        end
        chk("drain_level", level, 0);

        // Generator wrap, flush on exit, restart on re-entry
        drive(2'd2, 1'b0, 8'h00, 1'b1);
        cycle();
        cycle();
        for (int i = 0; i < 260; i++) begin
            chk("gen_data", tx_data, i % 256);
            cycle();
        end
        drive(2'd0, 1'b0, 8'h00, 1'b1);
        cycle();
        chk("flush_rx_ready", rx_ready, 0);
        chk("flush_tx_valid", tx_valid, 0);
        chk("flush_level", level, 0);
        cycle();
        drive(2'd2, 1'b0, 8'h00, 1'b1);
        cycle();
        cycle();
        chk("gen_restart_valid", tx_valid, 1);
        chk("gen_restart_data", tx_data, 0);
        cycle();

        // Asynchronous reset while bytes are queued
        drive(2'd0, 1'b0, 8'h00, 1'b0);
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(2'd0, 1'b1, 8'hA0 + 8'(i), 1'b0);
            cycle();
        end
        drive(2'd0, 1'b0, 8'h00, 1'b1);
        cycle();
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_rx_ready", rx_ready, 0);
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_level", level, 0);
        chk("arst_activity", activity, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        drive(2'd0, 1'b0, 8'h00, 1'b0);
        chk("arst_rel_rx_ready", rx_ready, 0);
        cycle();
        chk("arst_rel2_rx_ready", rx_ready, 1);
        chk("arst_rel2_level", level, 0);

        // Activity stretch and handshake counters
        cycle();
        drive(2'd0, 1'b1, 8'h33, 1'b0);
        cycle();
        drive(2'd0, 1'b0, 8'h00, 1'b0);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (activity) hi++;
            cycle();
        end
        chk("act_hold_cycles", hi, ACT_HOLD);
        drive(2'd0, 1'b1, 8'h34, 1'b0);
        cycle();
        cycle();
        drive(2'd0, 1'b0, 8'h00, 1'b1);
        cycle();
        cycle();
        drive(2'd0, 1'b0, 8'h00, 1'b0);
        cycle();
`ifdef USB_LOOPBACK_STATS_EN
        chk("stats_rx", rx_count, 3);
        chk("stats_tx", tx_count, 2);
`endif

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            logic [1:0] md;
            md = mode;
            if ($urandom_range(99) == 0) md = 2'($urandom_range(3));
            drive(md, $urandom_range(9) < 7, 8'($urandom),
                  $urandom_range(9) < (((i / 200) % 2 == 1) ? 8 : 2));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
